// File: rtl/pixel_conf_sequencer.sv
// Command sequencer for the per-pixel 8-bit config latch: write, read and write-verify of one pixel,
// with a glitch-free level-sensitive write strobe and a timed readback sample.
module pixel_conf_sequencer #(
  parameter int NUM_PIX  = 8,
  parameter int ADDR_W   = 3,
  parameter int WR_PULSE = 2,
  parameter int SETTLE   = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               CmdValid,
  output logic               CmdReady,
  input  logic               CmdWrite,
  input  logic               CmdVerify,
  input  logic [ADDR_W-1:0]  CmdAddr,
  input  logic [7:0]         CmdData,
  output logic               RspValid,
  input  logic               RspReady,
  output logic [7:0]         RspData,
  output logic               RspErr,
  output logic [NUM_PIX-1:0] PixSel,
  output logic               PixWr,
  output logic [7:0]         PixDataIn,
  input  logic [7:0]         PixDataOut
);

  // The capture step shares the last SETTLE cycle, so it has no state of its own.
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_SETTLE, S_RESP
  } state_t;

  localparam logic [3:0]      WR_LOAD = 4'(WR_PULSE - 1);
  localparam logic [3:0]      ST_LOAD = 4'(SETTLE - 1);
  localparam logic [ADDR_W:0] PIX_LIM = (ADDR_W+1)'(NUM_PIX);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          wdata_q;
  logic                write_q, verify_q, addr_ok_q;
  logic [7:0]          rsp_data_q;
  logic                rsp_err_q;

  logic accept, cmd_addr_ok, cnt_zero, sel_active;

  assign accept      = CmdValid && (state_q == S_IDLE);
  assign cmd_addr_ok = ({1'b0, CmdAddr} < PIX_LIM);
  assign cnt_zero    = (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      // Good-address reads skip SETUP: select and settle start together.
      S_IDLE:   if (CmdValid) state_d = (!CmdWrite && cmd_addr_ok) ? S_SETTLE : S_SETUP;
      S_SETUP:  if (!addr_ok_q)   state_d = S_RESP;
                else if (write_q) state_d = S_STROBE;
                else              state_d = S_SETTLE;
      S_STROBE: if (cnt_zero) state_d = S_HOLD;
      S_HOLD:   state_d = verify_q ? S_SETTLE : S_RESP;
      S_SETTLE: if (cnt_zero) state_d = S_RESP;
      S_RESP:   if (RspReady) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      write_q    <= 1'b0;
      verify_q   <= 1'b0;
      addr_ok_q  <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_STROBE && state_q != S_STROBE)      cnt_q <= WR_LOAD;
      else if (state_d == S_SETTLE && state_q != S_SETTLE) cnt_q <= ST_LOAD;
      else if (!cnt_zero)                                  cnt_q <= cnt_q - 4'd1;

      if (accept) begin
        addr_q     <= CmdAddr;
        write_q    <= CmdWrite;
        verify_q   <= CmdWrite && CmdVerify;
        addr_ok_q  <= cmd_addr_ok;
        rsp_data_q <= 8'h00;
        rsp_err_q  <= !cmd_addr_ok;
        // Write data only moves while idle, so it is frozen around the whole strobe window.
        if (CmdWrite && cmd_addr_ok) wdata_q <= CmdData;
      end

      if (state_q == S_SETTLE && cnt_zero) begin
        rsp_data_q <= PixDataOut;
        rsp_err_q  <= verify_q && (PixDataOut != wdata_q);
      end
    end
  end

  assign sel_active = addr_ok_q &&
                      (state_q == S_SETUP || state_q == S_STROBE ||
                       state_q == S_HOLD  || state_q == S_SETTLE);

  for (genvar i = 0; i < NUM_PIX; i++) begin : g_sel
    assign PixSel[i] = sel_active && (addr_q == ADDR_W'(i));
  end

  assign CmdReady  = (state_q == S_IDLE);
  assign RspValid  = (state_q == S_RESP);
  assign RspData   = rsp_data_q;
  assign RspErr    = rsp_err_q;
  assign PixWr     = (state_q == S_STROBE);
  assign PixDataIn = wdata_q;

endmodule
